// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port; RISC-V B/H/W sizing, 2^ADDR_W x 32-bit array.
// Latency: a request accepted in cycle c is answered (resp_valid high) in cycle c+LATENCY.
// Backpressure: one transaction in flight; response held until resp_ready. Optional DMEM_B2B_EN overlaps retire and accept.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic [3:0]          cnt_next;
    logic                accept;
    logic                enter_resp;

    logic                cap_write;
    logic [ADDR_W+1:0]   cap_addr;
    logic [31:0]         cap_wdata;
    logic [2:0]          cap_func3;

    logic                eff_write;
    logic [ADDR_W+1:0]   eff_addr;
    logic [31:0]         eff_wdata;
    logic [2:0]          eff_func3;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          off;
    logic                eff_err;
    logic [31:0]         mem_word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_ext;
    logic [3:0]          lane_en;
    logic [31:0]         wdata_lanes;
    logic                mem_we;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    // Address bits above the array size alias and are deliberately dropped.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_B2B_EN
    assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
`else
    assign req_ready = (state == IDLE);
`endif

    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // State register and latency down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; enter_resp marks the edge where the array is accessed.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE, RESP: begin
                if ((state == RESP) && resp_ready) begin
                    state_next = IDLE;
                end
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Hold the accepted request for the duration of WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
            cap_func3 <= 3'd0;
        end else if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr[ADDR_W+1:0];
            cap_wdata <= req_wdata;
            cap_func3 <= req_func3;
        end
    end

    // With LATENCY==1 the array is accessed on the accept edge, so the live request is used.
    always_comb begin
        if (state == WAIT) begin
            eff_write = cap_write;
            eff_addr  = cap_addr;
            eff_wdata = cap_wdata;
            eff_func3 = cap_func3;
        end else begin
            eff_write = req_write;
            eff_addr  = req_addr[ADDR_W+1:0];
            eff_wdata = req_wdata;
            eff_func3 = req_func3;
        end
    end

    assign word_idx = eff_addr[ADDR_W+1:2];
    assign off      = eff_addr[1:0];
    assign mem_word = mem[word_idx];
    assign half_sel = off[1] ? mem_word[31:16] : mem_word[15:0];

    // Size/sign decode: misalignment, illegal func3, unsigned sizes on stores.
    always_comb begin
        eff_err     = 1'b0;
        lane_en     = 4'b0000;
        wdata_lanes = eff_wdata;
        byte_sel    = mem_word[7:0];
        load_ext    = 32'd0;
        case (off)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        case (eff_func3)
            3'b000: begin
                lane_en     = 4'b0001 << off;
                wdata_lanes = {4{eff_wdata[7:0]}};
                load_ext    = {{24{byte_sel[7]}}, byte_sel};
            end
            3'b001: begin
                eff_err     = off[0];
                lane_en     = off[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{eff_wdata[15:0]}};
                load_ext    = {{16{half_sel[15]}}, half_sel};
            end
            3'b010: begin
                eff_err  = (off != 2'd0);
                lane_en  = 4'b1111;
                load_ext = mem_word;
            end
            3'b100: begin
                eff_err  = eff_write;
                load_ext = {24'd0, byte_sel};
            end
            3'b101: begin
                eff_err  = eff_write || off[0];
                load_ext = {16'd0, half_sel};
            end
            default: eff_err = 1'b1;
        endcase
    end

    assign mem_we = enter_resp && eff_write && !eff_err && !rst;

    // Byte-lane store commit; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // Response registers, loaded on RESP entry and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_err   <= eff_err;
            resp_rdata <= (eff_write || eff_err) ? 32'd0 : load_ext;
        end
    end

endmodule
